// File: rtl/rf_pkg.sv
// Shared constants, register aliases and the register index type for the register file.
package rf_pkg;

  localparam int unsigned RF_DATA_W     = 32;
  localparam int unsigned RF_NUM_REGS   = 32;
  localparam int unsigned RF_SP_INDEX   = 29;
  localparam int unsigned RF_SP_INITIAL = 24;
  localparam int unsigned RF_ADDR_W     = $clog2(RF_NUM_REGS);

  typedef logic [RF_ADDR_W-1:0] reg_idx_t;

  localparam reg_idx_t REG_ZERO = RF_ADDR_W'(0);
  localparam reg_idx_t REG_SP   = RF_ADDR_W'(29);
  localparam reg_idx_t REG_FP   = RF_ADDR_W'(30);
  localparam reg_idx_t REG_RA   = RF_ADDR_W'(31);

endpackage

// File: rtl/rf_scoreboard_bits.sv
// Pending-register scoreboard: claim/release/flush priority and registered pending count.
module rf_scoreboard_bits
  import rf_pkg::*;
#(
  parameter  int unsigned NUM_REGS = RF_NUM_REGS,
  localparam int unsigned ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic                claim_en,
  input  logic [ADDR_W-1:0]   claim_addr,
  input  logic                flush,
  output logic [NUM_REGS-1:0] pending,
  output logic                claim_ok,
  output logic [ADDR_W:0]     pending_cnt
);

  logic [NUM_REGS-1:0] pending_nxt;
  logic [ADDR_W:0]     cnt_nxt;

  // Claim acceptance and next pending vector; a claim beats a same-cycle release, flush beats both.
  always_comb begin
    claim_ok    = 1'b0;
    pending_nxt = pending;
    cnt_nxt     = '0;

    claim_ok = claim_en && !flush &&
               ((claim_addr == '0) || !pending[claim_addr] ||
                (wr_en && (wr_addr == claim_addr)));

    if (flush) begin
      pending_nxt = '0;
    end else begin
      if (wr_en && (wr_addr != '0)) pending_nxt[wr_addr] = 1'b0;
      if (claim_ok && (claim_addr != '0)) pending_nxt[claim_addr] = 1'b1;
    end
    pending_nxt[0] = 1'b0;

    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      cnt_nxt = cnt_nxt + (ADDR_W+1)'(pending_nxt[i]);
    end
  end

  // Pending bits and their population count update on the same edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pending     <= '0;
      pending_cnt <= '0;
    end else begin
      pending     <= pending_nxt;
      pending_cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/rf_scoreboard.sv
// Register file with N bypassed read ports, one write-back port and a pending scoreboard.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter  int unsigned DATA_W     = RF_DATA_W,
  parameter  int unsigned NUM_REGS   = RF_NUM_REGS,
  parameter  int unsigned NUM_RD     = 2,
  parameter  int unsigned SP_INDEX   = RF_SP_INDEX,
  parameter  int unsigned SP_INITIAL = RF_SP_INITIAL,
  localparam int unsigned ADDR_W     = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     claim_en,
  input  logic [ADDR_W-1:0]        claim_addr,
  output logic                     claim_ok,
  input  logic                     flush,
  output logic [ADDR_W:0]          pending_cnt
);

  if ((SP_INDEX < 1) || (SP_INDEX >= NUM_REGS)) begin : g_bad_sp
    $error("rf_scoreboard: SP_INDEX must lie in 1..NUM_REGS-1");
  end
  if ((NUM_REGS < 2) || ((NUM_REGS & (NUM_REGS - 1)) != 0)) begin : g_bad_regs
    $error("rf_scoreboard: NUM_REGS must be a power of two, at least 2");
  end
  if (NUM_RD < 1) begin : g_bad_rd
    $error("rf_scoreboard: NUM_RD must be at least 1");
  end

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] pending;

  rf_scoreboard_bits #(
    .NUM_REGS (NUM_REGS)
  ) u_bits (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .claim_en    (claim_en),
    .claim_addr  (claim_addr),
    .flush       (flush),
    .pending     (pending),
    .claim_ok    (claim_ok),
    .pending_cnt (pending_cnt)
  );

  // Data array: reset to zero except the stack pointer; writes to register 0 are dropped.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs[i] <= (i == SP_INDEX) ? DATA_W'(SP_INITIAL) : '0;
      end
    end else if (wr_en && (wr_addr != '0)) begin
      regs[wr_addr] <= wr_data;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic              wr_hit;

    assign addr   = rd_addr[k*ADDR_W +: ADDR_W];
    assign wr_hit = wr_en && (wr_addr == addr);

    // Read mux: register 0 reads zero, a same-cycle write is bypassed, else the stored value.
    always_comb begin
      rd_data[k*DATA_W +: DATA_W] = regs[addr];
      if (addr == '0)  rd_data[k*DATA_W +: DATA_W] = '0;
      else if (wr_hit) rd_data[k*DATA_W +: DATA_W] = wr_data;
    end

    assign rd_busy[k] = pending[addr] && !wr_hit;
  end

endmodule

// File: tb/tb_rf_scoreboard.sv
// Self-checking bench for rf_scoreboard: directed scenarios plus a randomised model run.
module tb_rf_scoreboard;
  import rf_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned NR = 2;

  logic            clk;
  logic            rst;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0]    rd_busy;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [DW-1:0]    wr_data;
  logic             claim_en;
  logic [AW-1:0]    claim_addr;
  logic             claim_ok;
  logic             flush;
  logic [AW:0]      pending_cnt;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_v;

  rf_scoreboard dut (
    .clk         (clk),
    .rst         (rst),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_busy     (rd_busy),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .claim_en    (claim_en),
    .claim_addr  (claim_addr),
    .claim_ok    (claim_ok),
    .flush       (flush),
    .pending_cnt (pending_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    claim_en = 1'b0; claim_addr = '0; flush = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0; idle_inputs(); rd_addr = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    rd_addr = {5'd5, REG_SP};
    exp_q.push_back(32'd24); exp_q.push_back(32'd0);
    exp_q.push_back(32'd0);  exp_q.push_back(32'd0);
    #1;
    checks++; exp_v = exp_q.pop_front();
    if (rd_data[31:0] !== exp_v) begin errors++; $display("FAIL reset_sp got=%0h exp=%0h", rd_data[31:0], exp_v); end
    checks++; exp_v = exp_q.pop_front();
    if (rd_data[63:32] !== exp_v) begin errors++; $display("FAIL reset_r5 got=%0h exp=%0h", rd_data[63:32], exp_v); end
    checks++; exp_v = exp_q.pop_front();
    if (32'(rd_busy) !== exp_v) begin errors++; $display("FAIL reset_busy got=%0h exp=%0h", rd_busy, exp_v); end
    checks++; exp_v = exp_q.pop_front();
    if (32'(pending_cnt) !== exp_v) begin errors++; $display("FAIL reset_cnt got=%0d exp=%0d", pending_cnt, exp_v); end
  endtask

  task automatic test_bypass();
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd8; wr_data = 32'hDEADBEEF; rd_addr = {5'd0, 5'd8};
    exp_q.push_back(32'hDEADBEEF); exp_q.push_back(32'd0);
    #1;
    checks++; exp_v = exp_q.pop_front();
    if (rd_data[31:0] !== exp_v) begin errors++; $display("FAIL bypass_data got=%0h exp=%0h", rd_data[31:0], exp_v); end
    checks++; exp_v = exp_q.pop_front();
    if (32'(rd_busy[0]) !== exp_v) begin errors++; $display("FAIL bypass_busy got=%0h exp=%0h", rd_busy[0], exp_v); end
    @(negedge clk);
    idle_inputs();
    exp_q.push_back(32'hDEADBEEF);
    #1;
    checks++; exp_v = exp_q.pop_front();
    if (rd_data[31:0] !== exp_v) begin errors++; $display("FAIL bypass_stored got=%0h exp=%0h", rd_data[31:0], exp_v); end
  endtask

  task automatic test_scoreboard();
    @(negedge clk);
    claim_en = 1'b1; claim_addr = 5'd3;
    exp_q.push_back(32'd1);
    #1;
    checks++; exp_v = exp_q.pop_front();
    if (32'(claim_ok) !== exp_v) begin errors++; $display("FAIL claim3_ok got=%0h exp=%0h", claim_ok, exp_v); end
    @(negedge clk);
    rd_addr = {5'd3, 5'd3};
    exp_q.push_back(32'd0); exp_q.push_back(32'd3); exp_q.push_back(32'd1);
    #1;
    checks++; exp_v = exp_q.pop_front();
    if (32'(claim_ok) !== exp_v) begin errors++; $display("FAIL reclaim3_ok got=%0h exp=%0h", claim_ok, exp_v); end
    checks++; exp_v = exp_q.pop_front();
    if (32'(rd_busy) !== exp_v) begin errors++; $display("FAIL claim3_busy got=%0h exp=%0h", rd_busy, exp_v); end
    checks++; exp_v = exp_q.pop_front();
    if (32'(pending_cnt) !== exp_v) begin errors++; $display("FAIL claim3_cnt got=%0d exp=%0d", pending_cnt, exp_v); end
    @(negedge clk);
    idle_inputs();
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'd7;
    exp_q.push_back(32'd1); exp_q.push_back(32'd0);
    #1;
    checks++; exp_v = exp_q.pop_front();
    if (32'(pending_cnt) !== exp_v) begin errors++; $display("FAIL retry_cnt got=%0d exp=%0d", pending_cnt, exp_v); end
    checks++; exp_v = exp_q.pop_front();
    if (32'(rd_busy) !== exp_v) begin errors++; $display("FAIL release_busy got=%0h exp=%0h", rd_busy, exp_v); end
    @(negedge clk);
    idle_inputs();
    exp_q.push_back(32'd0); exp_q.push_back(32'd7);
    #1;
    checks++; exp_v = exp_q.pop_front();
    if (32'(pending_cnt) !== exp_v) begin errors++; $display("FAIL release_cnt got=%0d exp=%0d", pending_cnt, exp_v); end
    checks++; exp_v = exp_q.pop_front();
    if (rd_data[31:0] !== exp_v) begin errors++; $display("FAIL release_data got=%0h exp=%0h", rd_data[31:0], exp_v); end
  endtask

  task automatic test_simultaneous();
    @(negedge clk);
    claim_en = 1'b1; claim_addr = 5'd4; wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h55;
    exp_q.push_back(32'd1);
    #1;
    checks++; exp_v = exp_q.pop_front();
    if (32'(claim_ok) !== exp_v) begin errors++; $display("FAIL claimwr4_ok got=%0h exp=%0h", claim_ok, exp_v); end
    @(negedge clk);
    idle_inputs();
    rd_addr = {5'd0, 5'd4};
    exp_q.push_back(32'h55); exp_q.push_back(32'd1); exp_q.push_back(32'd1);
    #1;
    checks++; exp_v = exp_q.pop_front();
    if (rd_data[31:0] !== exp_v) begin errors++; $display("FAIL claimwr4_data got=%0h exp=%0h", rd_data[31:0], exp_v); end
    checks++; exp_v = exp_q.pop_front();
    if (32'(rd_busy[0]) !== exp_v) begin errors++; $display("FAIL claimwr4_busy got=%0h exp=%0h", rd_busy[0], exp_v); end
    checks++; exp_v = exp_q.pop_front();
    if (32'(pending_cnt) !== exp_v) begin errors++; $display("FAIL claimwr4_cnt got=%0d exp=%0d", pending_cnt, exp_v); end
    @(negedge clk);
    flush = 1'b1; claim_en = 1'b1; claim_addr = 5'd9;
    exp_q.push_back(32'd0);
    #1;
    checks++; exp_v = exp_q.pop_front();
    if (32'(claim_ok) !== exp_v) begin errors++; $display("FAIL flush_ok got=%0h exp=%0h", claim_ok, exp_v); end
    @(negedge clk);
    idle_inputs();
    exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    #1;
    checks++; exp_v = exp_q.pop_front();
    if (32'(pending_cnt) !== exp_v) begin errors++; $display("FAIL flush_cnt got=%0d exp=%0d", pending_cnt, exp_v); end
    checks++; exp_v = exp_q.pop_front();
    if (32'(rd_busy[0]) !== exp_v) begin errors++; $display("FAIL flush_busy got=%0h exp=%0h", rd_busy[0], exp_v); end
  endtask

  task automatic test_reg0();
    @(negedge clk);
    wr_en = 1'b1; wr_addr = REG_ZERO; wr_data = 32'hFFFFFFFF;
    claim_en = 1'b1; claim_addr = REG_ZERO; rd_addr = {REG_ZERO, REG_ZERO};
    exp_q.push_back(32'd1); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    #1;
    checks++; exp_v = exp_q.pop_front();
    if (32'(claim_ok) !== exp_v) begin errors++; $display("FAIL r0_claim_ok got=%0h exp=%0h", claim_ok, exp_v); end
    checks++; exp_v = exp_q.pop_front();
    if (rd_data[31:0] !== exp_v) begin errors++; $display("FAIL r0_bypass got=%0h exp=%0h", rd_data[31:0], exp_v); end
    checks++; exp_v = exp_q.pop_front();
    if (32'(rd_busy) !== exp_v) begin errors++; $display("FAIL r0_busy got=%0h exp=%0h", rd_busy, exp_v); end
    @(negedge clk);
    idle_inputs();
    exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    #1;
    checks++; exp_v = exp_q.pop_front();
    if (rd_data[31:0] !== exp_v) begin errors++; $display("FAIL r0_stored got=%0h exp=%0h", rd_data[31:0], exp_v); end
    checks++; exp_v = exp_q.pop_front();
    if (32'(rd_busy) !== exp_v) begin errors++; $display("FAIL r0_busy_after got=%0h exp=%0h", rd_busy, exp_v); end
    checks++; exp_v = exp_q.pop_front();
    if (32'(pending_cnt) !== exp_v) begin errors++; $display("FAIL r0_cnt got=%0d exp=%0d", pending_cnt, exp_v); end
  endtask

  task automatic test_reset_mid();
    for (int r = 10; r <= 12; r++) begin
      @(negedge clk);
      claim_en = 1'b1; claim_addr = AW'(r);
    end
    @(negedge clk);
    idle_inputs();
    exp_q.push_back(32'd3);
    #1;
    checks++; exp_v = exp_q.pop_front();
    if (32'(pending_cnt) !== exp_v) begin errors++; $display("FAIL mid_pre_cnt got=%0d exp=%0d", pending_cnt, exp_v); end
    @(negedge clk);
    rst = 1'b0; wr_en = 1'b1; wr_addr = 5'd10; wr_data = 32'h1234;
    @(negedge clk);
    rst = 1'b1; idle_inputs();
    rd_addr = {REG_SP, 5'd10};
    exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'd24); exp_q.push_back(32'd0);
    #1;
    checks++; exp_v = exp_q.pop_front();
    if (32'(pending_cnt) !== exp_v) begin errors++; $display("FAIL mid_cnt got=%0d exp=%0d", pending_cnt, exp_v); end
    checks++; exp_v = exp_q.pop_front();
    if (rd_data[31:0] !== exp_v) begin errors++; $display("FAIL mid_r10 got=%0h exp=%0h", rd_data[31:0], exp_v); end
    checks++; exp_v = exp_q.pop_front();
    if (rd_data[63:32] !== exp_v) begin errors++; $display("FAIL mid_sp got=%0h exp=%0h", rd_data[63:32], exp_v); end
    checks++; exp_v = exp_q.pop_front();
    if (32'(rd_busy) !== exp_v) begin errors++; $display("FAIL mid_busy got=%0h exp=%0h", rd_busy, exp_v); end
  endtask

  task automatic test_random();
    logic [31:0] mem [32];
    logic [31:0] pend;
    logic [AW-1:0] ra [NR];
    logic hit;
    logic eok;
    int cnt;
    // Resynchronise DUT and model from a clean reset.
    @(negedge clk);
    rst = 1'b0; idle_inputs();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 32; i++) mem[i] = 32'd0;
    mem[29] = 32'd24;
    pend = 32'd0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      wr_en      = ($urandom_range(0, 1) == 1);
      wr_addr    = AW'($urandom_range(0, 7));
      wr_data    = $urandom;
      claim_en   = ($urandom_range(0, 2) != 0);
      claim_addr = AW'($urandom_range(0, 7));
      flush      = ($urandom_range(0, 15) == 0);
      for (int k = 0; k < NR; k++) begin
        ra[k] = ($urandom_range(0, 7) == 0) ? AW'(29) : AW'($urandom_range(0, 7));
        rd_addr[k*AW +: AW] = ra[k];
      end
      for (int k = 0; k < NR; k++) begin
        hit = wr_en && (wr_addr == ra[k]);
        exp_q.push_back((ra[k] == 0) ? 32'd0 : (hit ? wr_data : mem[ra[k]]));
        exp_q.push_back(32'(pend[ra[k]] && !hit));
      end
      eok = claim_en && !flush &&
            ((claim_addr == 0) || !pend[claim_addr] || (wr_en && (wr_addr == claim_addr)));
      exp_q.push_back(32'(eok));
      #1;
      for (int k = 0; k < NR; k++) begin
        checks++; exp_v = exp_q.pop_front();
        if (rd_data[k*DW +: DW] !== exp_v) begin errors++; $display("FAIL rnd_data cyc=%0d port=%0d got=%0h exp=%0h", cyc, k, rd_data[k*DW +: DW], exp_v); end
        checks++; exp_v = exp_q.pop_front();
        if (32'(rd_busy[k]) !== exp_v) begin errors++; $display("FAIL rnd_busy cyc=%0d port=%0d got=%0h exp=%0h", cyc, k, rd_busy[k], exp_v); end
      end
      checks++; exp_v = exp_q.pop_front();
      if (32'(claim_ok) !== exp_v) begin errors++; $display("FAIL rnd_claim cyc=%0d got=%0h exp=%0h", cyc, claim_ok, exp_v); end
      // Model update for the coming edge.
      if (wr_en && (wr_addr != 0)) mem[wr_addr] = wr_data;
      if (flush) pend = 32'd0;
      else begin
        if (wr_en && (wr_addr != 0)) pend[wr_addr] = 1'b0;
        if (eok && (claim_addr != 0)) pend[claim_addr] = 1'b1;
      end
      cnt = 0;
      for (int i = 0; i < 32; i++) cnt += int'(pend[i]);
      exp_q.push_back(32'(cnt));
      @(posedge clk);
      #1;
      checks++; exp_v = exp_q.pop_front();
      if (32'(pending_cnt) !== exp_v) begin errors++; $display("FAIL rnd_cnt cyc=%0d got=%0d exp=%0d", cyc, pending_cnt, exp_v); end
      @(negedge clk);
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1'b0;
    rd_addr = '0;
    idle_inputs();
    test_reset();
    test_bypass();
    test_scoreboard();
    test_simultaneous();
    test_reg0();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rf_scoreboard.md
Name: rf_scoreboard

Overview:
Parametrised next-generation register file for the pipelined MIPS core. It provides N read ports, one write-back port, and same-cycle write-to-read bypass. It includes a per-register pending scoreboard: decode claims a destination register, write-back releases it, and the hazard/stall logic reads the busy flags. It sits between decode (reads and claims), write-back (writes) and the hazard unit (busy flags, flush).

Parameters:
DATA_W, 32, register data width in bits
NUM_REGS, 32, number of architectural registers; power of two, at least 2; register 0 is hardwired to zero
NUM_RD, 2, number of independent read ports, at least 1
SP_INDEX, 29, index of the stack-pointer register
SP_INITIAL, 24, reset value loaded into register SP_INDEX
ADDR_W, $clog2(NUM_REGS), register index width (derived; do not override)

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  synchronous, active-low reset
rd_addr  in  NUM_RD*ADDR_W  packed read indices; port k uses slice k
rd_data  out  NUM_RD*DATA_W  packed read data, combinational
rd_busy  out  NUM_RD  per port: the register has an outstanding claim and no write is resolving it this cycle
wr_en  in  1  write-back strobe
wr_addr  in  ADDR_W  write-back index
wr_data  in  DATA_W  write-back data
claim_en  in  1  request to mark claim_addr pending
claim_addr  in  ADDR_W  destination register being claimed
claim_ok  out  1  combinational; claim is accepted this cycle
flush  in  1  clear all pending bits (pipeline squash); data is untouched
pending_cnt  out  ADDR_W+1  number of registers currently pending, registered

Behaviour:
- Reset: on a rising clk edge with rst=0, all registers are cleared to 0, except register SP_INDEX, which is loaded with SP_INITIAL. All pending bits are cleared and pending_cnt is set to 0. wr_en, claim_en and flush are ignored in that cycle.
- Reset has priority over everything. Asserting it mid-operation discards outstanding claims.
- Register 0:
  - Every read returns 0 and rd_busy=0.
  - Writes to index 0 are dropped.
  - A claim of index 0 is accepted (claim_ok=1) but sets no pending bit.
- Read path: fully combinational, zero latency. For port k:
  - If rd_addr_k == wr_addr, wr_en=1 and the index is nonzero, rd_data_k = wr_data (bypass).
  - Otherwise rd_data_k = the stored value.
- rd_busy_k = pending[rd_addr_k] AND NOT (wr_en AND wr_addr == rd_addr_k).
- Write: when wr_en=1 and wr_addr != 0, the register is updated at the clock edge and its pending bit is cleared at the same edge.
- Claim:
  - claim_ok = claim_en AND NOT flush AND (claim_addr == 0 OR NOT pending[claim_addr] OR (wr_en AND wr_addr == claim_addr)).
  - When claim_ok=1, pending[claim_addr] is set at the clock edge.
  - A rejected claim changes nothing. Decode must stall and retry.
- Same register written and claimed in one cycle: data is written and the pending bit ends at 1 (the claim wins over the release).
- Flush:
  - Clears every pending bit at the edge.
  - Forces claim_ok=0.
  - A write in the same cycle still updates data.
- pending_cnt: the registered population count of the pending bits, updated in the same edge as those bits. It is never negative and never exceeds NUM_REGS-1.
- No latches. The read mux is NUM_RD-wide through generate loops. The SP reset index is only valid when SP_INDEX is in 1..NUM_REGS-1; this is checked with an elaboration-time assertion.

Decomposition:
- Package rf_pkg holds:
  - default constants RF_DATA_W=32, RF_NUM_REGS=32, RF_SP_INDEX=29, RF_SP_INITIAL=24;
  - register alias localparams (REG_ZERO=0, REG_SP=29, REG_FP=30, REG_RA=31);
  - a typedef for the register index.
- One sub-module, rf_scoreboard_bits: owns the pending vector, the claim/release/flush priority and pending_cnt. It exports pending[] and claim_ok.
- The data array and the bypass read muxes stay in the top module.

Test Plan:
- Reset: hold rst=0 for 2 cycles, then read 29 and 5 -> rd_data=24 and 0; all rd_busy=0; pending_cnt=0.
- Bypass: wr_en=1, wr_addr=8, wr_data=0xDEADBEEF, rd_addr0=8 in the same cycle -> rd_data0=0xDEADBEEF combinationally and rd_busy0=0; one cycle later with wr_en=0 -> still 0xDEADBEEF.
- Scoreboard:
  - Claim reg 3 -> claim_ok=1; next cycle rd_busy=1 for reads of 3 and pending_cnt=1.
  - A second claim of 3 -> claim_ok=0.
  - Write 3 with value 7 -> rd_busy drops the same cycle; after the edge, pending_cnt=0 and the read returns 7.
- Simultaneous events:
  - Claim 4 and write 4 (0x55) in one cycle -> claim_ok=1; after the edge, reg 4=0x55 and pending[4] stays set (pending_cnt=1).
  - Flush with claim_en=1 on 9 -> claim_ok=0; after the edge, pending_cnt=0.
- Register 0: write 0 with 0xFFFFFFFF and claim 0 -> a read of 0 returns 0, rd_busy=0, pending_cnt unchanged.
- Reset mid-operation: claim 10, 11 and 12, then pulse rst=0 for one cycle while wr_en=1 writes reg 10 -> pending_cnt=0, reg 10=0, reg 29=24.
